fdiv: RTL and testbench

FDIV -- requirements
Module: fdiv

---
 rtl/fdiv.sv | 159 +++++++++++++++
 tb/tb_fdiv.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fdiv.sv
// Multi-cycle IEEE-754 binary32 divider: unpack, 25-step restoring division,
// round-to-nearest-even, registered result. Subnormals are flushed to zero.
module fdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_input,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid_output,
    output logic [WIDTH-1:0] y
);

    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, ROUND, OUTPUT} state_t;
    typedef enum logic [1:0] {SP_NORM, SP_NAN, SP_INF, SP_ZERO} spec_t;

    state_t             state_q;
    logic               valid_q;
    logic [WIDTH-1:0]   y_q;
    logic [4:0]         cnt_q;

    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic               sign_q, sign_d;
    logic signed [9:0]  exp_q, exp_d;
    spec_t              spec_q, spec_d;
    logic [25:0]        rem_q, rem_d;
    logic [23:0]        div_q, div_d;
    logic [24:0]        quo_q, quo_d;

    logic [23:0]        ma, mb;
    logic               ma_lt, rem_ge;
    logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [25:0]        rem_sub;

    // q holds 1.mantissa (24 bits) followed by the guard bit.
    function automatic logic [31:0] round_pack(input logic s, input logic signed [9:0] e,
                                               input logic [24:0] q, input logic sticky,
                                               input spec_t spec);
        logic              inc;
        logic [24:0]       sum;
        logic signed [9:0] e_f;
        logic [22:0]       frac;
        inc  = q[0] & (sticky | q[1]);
        sum  = {1'b0, q[24:1]} + {24'd0, inc};
        e_f  = e + $signed({9'd0, sum[24]});
        frac = sum[24] ? sum[23:1] : sum[22:0];
        case (spec)
            SP_NAN:  return 32'h7FC0_0000;
            SP_INF:  return {s, 8'hFF, 23'd0};
            SP_ZERO: return {s, 31'd0};
            default: begin
                if (e_f >= 10'sd255)     return {s, 8'hFF, 23'd0};
                else if (e_f <= 10'sd0)  return {s, 31'd0};
                else                     return {s, e_f[7:0], frac};
            end
        endcase
    endfunction

    always_comb begin
        ma      = {1'b1, a_q[22:0]};
        mb      = {1'b1, b_q[22:0]};
        ma_lt   = ma < mb;
        a_zero  = a_q[30:23] == 8'd0;
        b_zero  = b_q[30:23] == 8'd0;
        a_inf   = (&a_q[30:23]) && (a_q[22:0] == 23'd0);
        b_inf   = (&b_q[30:23]) && (b_q[22:0] == 23'd0);
        a_nan   = (&a_q[30:23]) && (a_q[22:0] != 23'd0);
        b_nan   = (&b_q[30:23]) && (b_q[22:0] != 23'd0);
        rem_ge  = rem_q >= {2'b00, div_q};
        rem_sub = rem_ge ? rem_q - {2'b00, div_q} : rem_q;

        a_d    = a_q;
        b_d    = b_q;
        sign_d = sign_q;
        exp_d  = exp_q;
        spec_d = spec_q;
        rem_d  = rem_q;
        div_d  = div_q;
        quo_d  = quo_q;
        res_d  = res_q;
        case (state_q)
            IDLE: begin
                if (valid_input) begin
                    a_d = a;
                    b_d = b;
                end
            end
            UNPACK: begin
                sign_d = a_q[31] ^ b_q[31];
                // Pre-normalise so the quotient lands in [1,2).
                exp_d  = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
                       + 10'sd127 - (ma_lt ? 10'sd1 : 10'sd0);
                rem_d  = ma_lt ? {1'b0, ma, 1'b0} : {2'b00, ma};
                div_d  = mb;
                quo_d  = '0;
                if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
                    spec_d = SP_NAN;
                else if (a_inf || b_zero)
                    spec_d = SP_INF;
                else if (a_zero || b_inf)
                    spec_d = SP_ZERO;
                else
                    spec_d = SP_NORM;
            end
            DIVIDE: begin
                rem_d = rem_sub << 1;
                quo_d = {quo_q[23:0], rem_ge};
            end
            ROUND: res_d = round_pack(sign_q, exp_q, quo_q, rem_q != 26'd0, spec_q);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE:   if (valid_input) state_q <= UNPACK;
                UNPACK: begin
                    cnt_q   <= '0;
                    state_q <= DIVIDE;
                end
                DIVIDE: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd24) state_q <= ROUND;
                end
                ROUND:  state_q <= OUTPUT;
                OUTPUT: begin
                    y_q     <= res_q;
                    valid_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        sign_q <= sign_d;
        exp_q  <= exp_d;
        spec_q <= spec_d;
        rem_q  <= rem_d;
        div_q  <= div_d;
        quo_q  <= quo_d;
        res_q  <= res_d;
    end

    assign valid_output = valid_q;
    assign y            = y_q;

endmodule

// File: tb/tb_fdiv.sv
// Scoreboard bench for fdiv: issued requests push expected results computed
// by an integer-arithmetic reference; a negedge monitor pops and compares.
module tb_fdiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_input = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        valid_output;
    logic [31:0] y;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic prev_v = 1'b0;

    typedef struct {
        logic [31:0] y;
        int          cyc;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;
    exp_t sb[$];

    fdiv #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .valid_input(valid_input),
        .a(a), .b(b), .valid_output(valid_output), .y(y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] d);
        logic        s;
        int          ex, ed, e, sh;
        logic [63:0] mx, md, num, q, r, m, rest, half;
        logic        up;
        s  = x[31] ^ d[31];
        ex = int'(x[30:23]);
        ed = int'(d[30:23]);
        if ((ex == 255 && x[22:0] != 0) || (ed == 255 && d[22:0] != 0) ||
            (ex == 0 && ed == 0) || (ex == 255 && ed == 255))
            return 32'h7FC0_0000;
        if (ex == 255 || ed == 0) return {s, 8'hFF, 23'd0};
        if (ex == 0 || ed == 255) return {s, 31'd0};
        mx  = {40'd0, 1'b1, x[22:0]};
        md  = {40'd0, 1'b1, d[22:0]};
        num = mx << 39;
        q   = num / md;
        r   = num % md;
        e   = ex - ed + 127;
        if (q >= (64'd1 << 39)) sh = 16;
        else begin
            sh = 15;
            e  = e - 1;
        end
        m    = q >> sh;
        rest = q & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        up   = (rest > half) || (rest == half && (r != 0 || m[0]));
        m    = m + {63'd0, up};
        if (m == (64'd1 << 24)) begin
            m = 64'd1 << 23;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0)   return {s, 31'd0};
        return {s, e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        int          mode;
        logic [7:0]  e;
        logic [22:0] f;
        mode = int'($urandom_range(0, 15));
        f    = 23'($urandom);
        if (mode == 0) e = 8'd0;
        else if (mode == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 1) f = '0;
        end else if (mode <= 4) e = 8'($urandom_range(1, 254));
        else e = 8'($urandom_range(110, 144));
        return {1'($urandom), e, f};
    endfunction

    // Monitor: result value, 28-edge latency and single-cycle strobe.
    always @(negedge clk) begin
        exp_t e;
        if (prev_v) begin
            checks++;
            if (valid_output !== 1'b0) begin
                errors++;
                $display("FAIL pulse_width valid_output=%b required=0 at cycle %0d", valid_output, cyc);
            end
        end
        prev_v = (valid_output === 1'b1);
        if (valid_output === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output y=%h with nothing outstanding at cycle %0d", y, cyc);
            end else begin
                e = sb.pop_front();
                checks++;
                if (y !== e.y) begin
                    errors++;
                    $display("FAIL quotient a=%h b=%h got=%h required=%h", e.a, e.b, y, e.y);
                end
                checks++;
                if (cyc - e.cyc != 28) begin
                    errors++;
                    $display("FAIL latency a=%h b=%h got=%0d required=28", e.a, e.b, cyc - e.cyc);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] aa, input logic [31:0] bb);
        exp_t e;
        @(negedge clk);
        a = aa;
        b = bb;
        valid_input = 1'b1;
        e.y = ref_div(aa, bb);
        e.cyc = cyc + 1;
        e.a = aa;
        e.b = bb;
        sb.push_back(e);
        @(negedge clk);
        valid_input = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout outstanding=%0d required=0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (valid_output !== 1'b0) begin
            errors++;
            $display("FAIL %s_valid got=%b required=0", name, valid_output);
        end
        checks++;
        if (y !== 32'd0) begin
            errors++;
            $display("FAIL %s_y got=%h required=00000000", name, y);
        end
    endtask

    logic [31:0] dir_a [13] = '{32'h3F800000, 32'h40C00000, 32'hC0C00000, 32'h3F800000,
                                32'h3F800000, 32'h00000000, 32'h7F800000, 32'h3F800000,
                                32'h7FC00000, 32'h7F7FFFFF, 32'h00800000, 32'hBF800000,
                                32'h00000000};
    logic [31:0] dir_b [13] = '{32'h3F800000, 32'h40000000, 32'h40000000, 32'h40400000,
                                32'h00000000, 32'h00000000, 32'h7F800000, 32'h7F800000,
                                32'h3F800000, 32'h3F000000, 32'h40000000, 32'h00000000,
                                32'hC0000000};

    initial begin
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        foreach (dir_a[i]) begin
            issue(dir_a[i], dir_b[i]);
            drain();
        end

        // A request strobed while busy must be dropped.
        issue(32'h3F800000, 32'h40400000);
        repeat (4) @(negedge clk);
        a = 32'h40000000;
        b = 32'h3F800000;
        valid_input = 1'b1;
        @(negedge clk);
        valid_input = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Reset mid-operation aborts with no result strobe.
        issue(32'h40C00000, 32'h40000000);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_reset");
        repeat (40) @(negedge clk);
        issue(32'h3F800000, 32'h3F800000);
        drain();

        for (int i = 0; i < 60; i++) begin
            issue(rnd_fp(), rnd_fp());
            drain();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
